// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// No logic; pure declarations.
// No flow control; consumers own their handshakes.
package imem_loader_pkg;

    localparam int ADDR_W_DEF     = 8;
    localparam int INSTR_W_DEF    = 24;
    localparam int BYTES_PER_WORD = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DATA  = 2'd2,
        ST_CHECK = 2'd3
    } ld_state_t;

endpackage

// File: rtl/imem_byte_assembler.sv
// Packs a byte stream MSB-first into instruction words.
// word_done pulses one cycle after the last byte of a word shifts in.
// No backpressure of its own; shifts only when shift_en is high.
module imem_byte_assembler
    import imem_loader_pkg::*;
#(
    parameter int NBYTES = BYTES_PER_WORD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [7:0]            in_byte,
    output logic [8*NBYTES-1:0]   word,
    output logic [1:0]            byte_idx,
    output logic                  word_done
);

    localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            word      <= '0;
            byte_idx  <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (clear) begin
                byte_idx <= '0;
            end else if (shift_en) begin
                word <= {word[8*NBYTES-9:0], in_byte};
                if (byte_idx == LAST_IDX) begin
                    byte_idx  <= '0;
                    word_done <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a count/data/checksum byte stream into instruction memory.
// Each word is written one cycle after its third byte is accepted.
// in_ready is high in every non-idle state; writes never stall the stream.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic [7:0]         in_byte,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_waddr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               core_hold,
    output logic               load_done,
    output logic               load_err
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    ld_state_t         state_q, state_d;
    logic [ADDR_W-1:0] n_words;
    logic [ADDR_W-1:0] wcnt;
    logic [7:0]        csum;
    logic [1:0]        byte_idx;
    logic              xfer;
    logic              last_byte;
    logic              last_word;
    logic              asm_clear;
    logic              asm_shift;

    assign xfer      = in_valid && in_ready;
    assign last_byte = (byte_idx == LAST_IDX);
    // N=0 encodes 2^ADDR_W words, which the modular N-1 compare covers for free.
    assign last_word = (wcnt == n_words - ADDR_W'(1));
    assign asm_clear = (state_q == ST_COUNT) && xfer;
    assign asm_shift = (state_q == ST_DATA) && xfer;

    imem_byte_assembler #(.NBYTES(BYTES_PER_WORD)) u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .shift_en  (asm_shift),
        .in_byte   (in_byte),
        .word      (imem_wdata),
        .byte_idx  (byte_idx),
        .word_done (imem_we)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (load_start) state_d = ST_COUNT;
            ST_COUNT: if (xfer) state_d = ST_DATA;
            ST_DATA:  if (xfer && last_byte && last_word) state_d = ST_CHECK;
            ST_CHECK: if (xfer) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != ST_IDLE);
        core_hold = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_words    <= '0;
            wcnt       <= '0;
            csum       <= '0;
            imem_waddr <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (xfer) begin
                        n_words <= ADDR_W'(in_byte);
                        wcnt    <= '0;
                        csum    <= '0;
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        csum <= csum ^ in_byte;
                        if (last_byte) begin
                            imem_waddr <= wcnt;
                            wcnt       <= wcnt + ADDR_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (xfer) begin
                        load_done <= 1'b1;
                        load_err  <= (in_byte != csum);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [23:0] imem_wdata;
    logic        core_hold;
    logic        load_done;
    logic        load_err;

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] exp_words [256];
    logic [7:0]  got_addr [$];
    logic [23:0] got_data [$];

    imem_loader #(.ADDR_W(8), .INSTR_W(24)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            got_addr.push_back(imem_waddr);
            got_data.push_back(imem_wdata);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bub);
        if (bub) begin
            while ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom);
                tick();
            end
        end
        in_valid = 1'b1;
        in_byte  = b;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL in_ready_during_load: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        vectors++;
        if (core_hold !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin
            miscompares++;
            $display("FAIL start_state: hold/done/err got %b%b%b want 100",
                     core_hold, load_done, load_err);
        end
    endtask

    // Drives a complete load of nw words from exp_words; returns the model checksum.
    task automatic drive_load(input int nw, input bit use_cs, input logic [7:0] cs_val,
                              input bit bub, input bit poke, output logic [7:0] model_cs);
        logic [7:0]  cs;
        logic [23:0] w;
        cs = 8'h00;
        got_addr.delete();
        got_data.delete();
        pulse_start();
        send_byte(8'(nw % 256), bub);
        for (int i = 0; i < nw; i++) begin
            w = exp_words[i];
            for (int b = 2; b >= 0; b--) begin
                cs = cs ^ w[8*b +: 8];
                send_byte(w[8*b +: 8], bub);
                if (poke && i == 0 && b == 2) begin
                    load_start = 1'b1;
                    tick();
                    load_start = 1'b0;
                end
            end
        end
        send_byte(use_cs ? cs_val : cs, bub);
        model_cs = cs;
    endtask

    task automatic check_load(input string name, input int nw, input bit exp_err);
        vectors++;
        if (got_addr.size() != nw) begin
            miscompares++;
            $display("FAIL %s_write_count: got %0d want %0d", name, got_addr.size(), nw);
        end
        for (int i = 0; i < nw && i < got_addr.size(); i++) begin
            vectors++;
            if (got_addr[i] !== 8'(i) || got_data[i] !== exp_words[i]) begin
                miscompares++;
                $display("FAIL %s_write%0d: got %h=%h want %h=%h", name, i,
                         got_addr[i], got_data[i], 8'(i), exp_words[i]);
            end
        end
        vectors++;
        if (load_done !== 1'b1 || load_err !== exp_err || core_hold !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_flags: done/err/hold/rdy got %b%b%b%b want 1%b00", name,
                     load_done, load_err, core_hold, in_ready, exp_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load_start = 1'b1; in_valid = 1'b1; in_byte = 8'hA5;
        tick(); tick();
        vectors++;
        if ({in_ready, imem_we, imem_waddr, imem_wdata, core_hold, load_done, load_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b",
                     in_ready, imem_we, imem_waddr, imem_wdata, core_hold, load_done, load_err);
        end
        reset = 1'b0; load_start = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] cs;
        exp_words[0] = 24'h123456;
        exp_words[1] = 24'hABCDEF;
        drive_load(2, 1'b1, 8'hF9, 1'b0, 1'b0, cs);
        vectors++;
        if (cs !== 8'hF9) begin
            miscompares++;
            $display("FAIL basic_model_checksum: got %h want f9", cs);
        end
        check_load("basic", 2, 1'b0);
    endtask

    task automatic test_bad_checksum();
        logic [7:0] cs;
        drive_load(2, 1'b1, 8'h00, 1'b0, 1'b0, cs);
        check_load("badcs", 2, 1'b1);
    endtask

    task automatic test_bubbles();
        logic [7:0] cs;
        drive_load(2, 1'b1, 8'hF9, 1'b1, 1'b0, cs);
        check_load("bubbles", 2, 1'b0);
    endtask

    task automatic test_full_n0();
        logic [7:0] cs;
        for (int k = 0; k < 256; k++) exp_words[k] = {8'(k), 8'(k), 8'(k)};
        drive_load(256, 1'b0, 8'h00, 1'b0, 1'b0, cs);
        check_load("n0", 256, 1'b0);
        tick(); tick();
        vectors++;
        if (got_addr.size() != 256 || got_addr[255] !== 8'hFF || got_data[255] !== 24'hFFFFFF) begin
            miscompares++;
            $display("FAIL n0_last_write: count %0d last %h=%h want 256 ff=ffffff",
                     got_addr.size(), got_addr[got_addr.size()-1], got_data[got_data.size()-1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] cs;
        exp_words[0] = 24'h123456;
        exp_words[1] = 24'hABCDEF;
        got_addr.delete();
        got_data.delete();
        pulse_start();
        send_byte(8'd2, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'hAB, 1'b0);
        reset = 1'b1;
        in_valid = 1'b1;
        load_start = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0; load_start = 1'b0;
        vectors++;
        if ({in_ready, imem_we, imem_waddr, imem_wdata, core_hold, load_done, load_err} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b",
                     in_ready, imem_we, imem_waddr, imem_wdata, core_hold, load_done, load_err);
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_byte = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        vectors++;
        if (got_addr.size() != 1 || got_addr[0] !== 8'h00 || got_data[0] !== 24'h123456) begin
            miscompares++;
            $display("FAIL midreset_writes: count %0d want 1 (addr0=123456)", got_addr.size());
        end
        for (int i = 0; i < 3; i++) exp_words[i] = 24'($urandom);
        drive_load(3, 1'b0, 8'h00, 1'b0, 1'b0, cs);
        check_load("after_reset", 3, 1'b0);
    endtask

    task automatic test_ignored_inputs();
        logic [7:0] cs;
        logic       done_before;
        got_addr.delete();
        got_data.delete();
        done_before = load_done;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_byte = 8'($urandom);
            tick();
            vectors++;
            if (in_ready !== 1'b0 || core_hold !== 1'b0 || load_done !== done_before) begin
                miscompares++;
                $display("FAIL idle_valid: rdy/hold/done got %b%b%b want 00%b",
                         in_ready, core_hold, load_done, done_before);
            end
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (got_addr.size() != 0) begin
            miscompares++;
            $display("FAIL idle_valid_writes: got %0d want 0", got_addr.size());
        end
        for (int i = 0; i < 4; i++) exp_words[i] = 24'($urandom);
        drive_load(4, 1'b0, 8'h00, 1'b0, 1'b1, cs);
        check_load("start_in_data", 4, 1'b0);
    endtask

    task automatic test_random_loads();
        logic [7:0] cs;
        int         nw;
        bit         bad;
        logic [7:0] badv;
        for (int t = 0; t < 6; t++) begin
            nw  = $urandom_range(1, 9);
            bad = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < nw; i++) exp_words[i] = 24'($urandom);
            cs = 8'h00;
            for (int i = 0; i < nw; i++)
                cs = cs ^ exp_words[i][23:16] ^ exp_words[i][15:8] ^ exp_words[i][7:0];
            badv = cs ^ 8'(1 << $urandom_range(0, 7));
            drive_load(nw, bad, badv, 1'b1, 1'b0, cs);
            check_load("random", nw, bad);
        end
    endtask

    initial begin
        reset = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        test_reset();
        test_basic();
        test_bad_checksum();
        test_bubbles();
        test_full_n0();
        test_reset_mid();
        test_ignored_inputs();
        test_random_loads();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
